// File: rtl/benchmark_pkg.sv
// Shared encodings, ASCII constants and message geometry for the benchmark status reporter.
package benchmark_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        COND_BASE2  = 2'b00,
        COND_BASE10 = 2'b01,
        COND_BASE12 = 2'b10,
        COND_ROUTER = 2'b11
    } cond_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_W     = 8'h57;

    localparam int unsigned NUM_CONDS     = 4;
    localparam int unsigned WORD_LINE_LEN = 13;
    localparam int unsigned WIN_LINE_LEN  = 5;
    localparam int unsigned MSG_LEN       = NUM_CONDS * WORD_LINE_LEN + WIN_LINE_LEN;

    function automatic logic [15:0] cond_tag(input cond_t c);
        case (c)
            COND_BASE2:  return "B2";
            COND_BASE10: return "BA";
            COND_BASE12: return "BC";
            default:     return "RT";
        endcase
    endfunction

    // Uppercase hex: 'A' - 10 = 0x37
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/benchmark_reporter_uart.sv
// 8N1 UART byte transmitter; tx_busy drops during the final stop-bit cycle so a
// following frame can start on the very edge the stop bit ends.
module uart_tx_byte
    import benchmark_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    logic        active;
    logic [15:0] timer;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        last_tick;

    assign last_tick = active && (bit_cnt == 4'd9) && (timer == '0);
    assign tx_busy   = active && !last_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (tx_start && !tx_busy) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            timer   <= 16'(CLKS_PER_BIT - 1);
            bit_cnt <= '0;
            shreg   <= tx_data;
        end else if (active) begin
            if (timer != '0) begin
                timer <= timer - 16'd1;
            end else begin
                timer <= 16'(CLKS_PER_BIT - 1);
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/benchmark_reporter.sv
// Snapshots benchmark totals on each completion and streams them as ASCII over UART.
module benchmark_reporter
    import benchmark_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        benchmark_done,
    input  logic [31:0] cycles_base2,
    input  logic [31:0] cycles_base10,
    input  logic [31:0] cycles_base12,
    input  logic [31:0] cycles_router,
    input  logic [3:0]  winner_leds,
    output logic        uart_tx,
    output logic        report_busy,
    output logic        report_done
);

    state_t      state;
    logic        done_q;
    logic        rise;
    logic [31:0] snap_cycles [NUM_CONDS];
    logic [3:0]  snap_winner;
    logic [5:0]  byte_index;
    logic [4:0]  field;
    logic [4:0]  char_idx;
    logic [4:0]  last_char;
    logic [7:0]  cur_char;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] tag;
    logic [2:0]  nib_sel;
    logic [31:0] word;

    assign rise      = benchmark_done && !done_q;
    assign last_char = (field < 5'(NUM_CONDS)) ? 5'(WORD_LINE_LEN - 1) : 5'(WIN_LINE_LEN - 1);

    always_comb begin
        cur_char = ASCII_LF;
        tag      = '0;
        nib_sel  = '0;
        word     = snap_cycles[field[1:0]];
        if (field < 5'(NUM_CONDS)) begin
            tag = cond_tag(cond_t'(field[1:0]));
            case (char_idx)
                5'd0:    cur_char = tag[15:8];
                5'd1:    cur_char = tag[7:0];
                5'd2:    cur_char = ASCII_COLON;
                5'd11:   cur_char = ASCII_CR;
                5'd12:   cur_char = ASCII_LF;
                default: begin
                    // chars 3..10 map to nibbles 7..0
                    nib_sel  = 3'(5'd10 - char_idx);
                    cur_char = hex_ascii(word[{nib_sel, 2'b00} +: 4]);
                end
            endcase
        end else begin
            case (char_idx)
                5'd0:    cur_char = ASCII_W;
                5'd1:    cur_char = ASCII_COLON;
                5'd2:    cur_char = hex_ascii(snap_winner);
                5'd3:    cur_char = ASCII_CR;
                default: cur_char = ASCII_LF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            done_q      <= 1'b0;
            report_busy <= 1'b0;
            report_done <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            byte_index  <= '0;
            field       <= '0;
            char_idx    <= '0;
            snap_winner <= '0;
            for (int unsigned i = 0; i < NUM_CONDS; i++) snap_cycles[i] <= '0;
        end else begin
            done_q      <= benchmark_done;
            report_done <= 1'b0;
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (rise) begin
                        snap_cycles[0] <= cycles_base2;
                        snap_cycles[1] <= cycles_base10;
                        snap_cycles[2] <= cycles_base12;
                        snap_cycles[3] <= cycles_router;
                        snap_winner    <= winner_leds;
                        report_busy    <= 1'b1;
                        byte_index     <= '0;
                        field          <= '0;
                        char_idx       <= '0;
                        state          <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    tx_data  <= cur_char;
                    tx_start <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    tx_start <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // tx_busy is already low in the last stop-bit cycle, giving a 2-cycle gap
                    if (!tx_busy) begin
                        if (byte_index == 6'(MSG_LEN - 1)) begin
                            report_done <= 1'b1;
                            report_busy <= 1'b0;
                            state       <= ST_FINISH;
                        end else begin
                            byte_index <= byte_index + 6'd1;
                            if (char_idx == last_char) begin
                                char_idx <= '0;
                                field    <= field + 5'd1;
                            end else begin
                                char_idx <= char_idx + 5'd1;
                            end
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx      (uart_tx)
    );

endmodule
